down_count_monitor: RTL

//  Downstream checker for the free-running synchronous down counter. Samples its

---
 rtl/down_count_pkg.sv | 27 ++
 rtl/sat_counter.sv | 27 ++
 rtl/down_count_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/down_count_pkg.sv
// Shared definitions for the down-counter monitor.
//   - FSM state encodings (EMPTY, ACQ, TRACK)
//   - all_ones(): all-ones pattern of a given width (reload / wrap target)
//   - width_ok() / lock_samples_ok(): parameter range checks used at elaboration
package down_count_pkg;

  localparam logic [1:0] EMPTY = 2'd0;  // nothing sampled since reset
  localparam logic [1:0] ACQ   = 2'd1;  // counting consecutive good decrements
  localparam logic [1:0] TRACK = 2'd2;  // locked; every step is checked

  localparam int RUN_W = 4;  // run counter width; holds LOCK_SAMPLES up to 15

  // Helper is 32 bits wide, which bounds the supported count width.
  function automatic logic [31:0] all_ones(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

  function automatic bit lock_samples_ok(input int n);
    return (n >= 1) && (n <= 15);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the monitor's statistics.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset (q -> 0)
//   clr  in   synchronous clear (q -> 0); wins over inc
//   inc  in   increment request; ignored once q is all-ones
//   q    out  CNT_W-bit count, sticks at 2^CNT_W-1
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// Downstream checker for a free-running synchronous down counter.
// Each valid sample is compared against the previous one: a decrement by one
// (mod 2^WIDTH) is a match, a jump to all-ones from non-zero is a reload,
// anything else is bad. After LOCK_SAMPLES consecutive matches the monitor
// locks (TRACK) and from then on reports terminal count, wrap and error
// events, with saturating statistics.
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   cnt_in        in   WIDTH  count value from the upstream counter
//   cnt_valid     in   sample strobe
//   clr           in   clears wrap_count, err_count, err_sticky
//   locked        out  high while in TRACK
//   tc_pulse      out  0 sampled while tracking
//   wrap_pulse    out  0 -> all-ones step while tracking
//   reload_pulse  out  non-wrap jump to all-ones (ACQ or TRACK)
//   err_pulse     out  bad step while tracking
//   err_sticky    out  latched error flag
//   wrap_count    out  CNT_W  saturating wrap counter
//   err_count     out  CNT_W  saturating error counter
module down_count_monitor
  import down_count_pkg::*;
#(
  parameter int WIDTH        = 3,
  parameter int LOCK_SAMPLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             clr,
  output logic             locked,
  output logic             tc_pulse,
  output logic             wrap_pulse,
  output logic             reload_pulse,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("down_count_monitor: WIDTH must be in 2..32");
  end
  if (!lock_samples_ok(LOCK_SAMPLES)) begin : g_bad_lock
    $error("down_count_monitor: LOCK_SAMPLES must be in 1..15");
  end

  localparam logic [WIDTH-1:0] ONES   = WIDTH'(all_ones(WIDTH));
  localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_SAMPLES);

  logic [1:0]       state, state_next;
  logic [RUN_W-1:0] run, run_next, run_inc;
  logic [WIDTH-1:0] prev, exp_cnt;
  logic             match, wrap, reload;
  logic             tc_next, wrap_next, reload_next, err_next;

  // Classifier. match and reload are mutually exclusive: the only step that
  // lands on all-ones as a match is from 0, which reload excludes.
  assign exp_cnt = prev - WIDTH'(1);
  assign match   = (cnt_in == exp_cnt);
  assign wrap    = match && (prev == '0);
  assign reload  = (cnt_in == ONES) && (prev != '0);
  assign run_inc = run + RUN_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    run_next    = run;
    tc_next     = 1'b0;
    wrap_next   = 1'b0;
    reload_next = 1'b0;
    err_next    = 1'b0;
    if (cnt_valid) begin
      case (state)
        EMPTY: begin
          state_next = ACQ;
          run_next   = '0;
        end
        ACQ: begin
          // Reloads are reported while acquiring; errors, tc and wraps are not.
          reload_next = reload;
          if (match) begin
            if (run_inc == LOCK_N) begin
              state_next = TRACK;
              run_next   = '0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = '0;
          end
        end
        TRACK: begin
          if (match) begin
            tc_next   = (cnt_in == '0);
            wrap_next = wrap;
          end else if (reload) begin
            reload_next = 1'b1;
            state_next  = ACQ;
            run_next    = '0;
          end else begin
            err_next   = 1'b1;
            state_next = ACQ;
            run_next   = '0;
          end
        end
        default: begin
          state_next = EMPTY;
          run_next   = '0;
        end
      endcase
    end
  end

  // NOTE: reset is synchronous, so it is simply the highest-priority branch
  // inside the clocked block rather than part of the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      run          <= '0;
      prev         <= '0;
      tc_pulse     <= 1'b0;
      wrap_pulse   <= 1'b0;
      reload_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      state        <= state_next;
      run          <= run_next;
      if (cnt_valid) prev <= cnt_in;
      tc_pulse     <= tc_next;
      wrap_pulse   <= wrap_next;
      reload_pulse <= reload_next;
      err_pulse    <= err_next;
      // clr beats a simultaneous error; the err_pulse itself still fires.
      if (clr)           err_sticky <= 1'b0;
      else if (err_next) err_sticky <= 1'b1;
    end
  end

  assign locked = (state == TRACK);

  sat_counter #(.CNT_W(CNT_W)) u_wrap_count (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_next),
    .q   (wrap_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_count (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_next),
    .q   (err_count)
  );

endmodule
